// File: rtl/rd_fwft_stage.sv
// Read-side FWFT output stage: pops the FIFO memory and re-presents words as a valid/ready stream.
// Optional macro FWFT_STATS_EN adds the rd_count accepted-transfer counter and port.
module rd_fwft_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FWFT_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

  localparam int unsigned Depth = 3;

  if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("DATA_WIDTH and CNT_WIDTH must be nonzero");
  end

  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic fire;
  logic capture;
  logic pop;

  function automatic logic [1:0] idx_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Words already owned (buffered or on their way from memory) must leave room for one more.
  assign r_en    = !empty && (({1'b0, count_q} + {2'b00, inflight_q}) < 3'(Depth));
  assign fire    = r_en && !empty;
  assign capture = inflight_q;
  assign m_valid = (count_q != 2'd0);
  assign pop     = m_valid && m_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (capture) begin
      tail_d = idx_next(tail_q);
    end
    if (pop) begin
      head_d = idx_next(head_q);
    end
    unique case ({capture, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    m_data = mem_q[0];
    case (head_q)
      2'd1:    m_data = mem_q[1];
      2'd2:    m_data = mem_q[2];
      default: m_data = mem_q[0];
    endcase
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      inflight_q <= fire;
      head_q     <= head_d;
      tail_q     <= tail_d;
      for (int i = 0; i < Depth; i++) begin
        if (capture && (tail_q == 2'(i))) begin
          mem_q[i] <= rdata;
        end
      end
    end
  end

`ifdef FWFT_STATS_EN
  logic [CNT_WIDTH-1:0] rd_count_q;

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_count_q <= '0;
    end else if (pop) begin
      rd_count_q <= rd_count_q + 1'b1;
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule
